fetch_sequencer: RTL and testbench

Fetch controller for the byte-addressed, synchronous-read instruction memory. It owns the program counter, drives the memory address every cycle, and tracks the one-cycle read latency. Returned words go into a 2-entry skid buffer that feeds decode over a valid/ready handshake. Redirects (branch/jump) squash in-flight and buffered fetches, and out-of-range or misaligned fetch addresses are trapped.

---
 rtl/fetch_sequencer.sv | 148 ++++++++++++++
 tb/tb_fetch_sequencer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Instruction fetch controller: owns the PC, tracks one-cycle memory read latency,
// and buffers returned words in a 2-entry skid FIFO feeding decode.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC  = 32'd0,
    parameter int unsigned MEM_BYTES = 2048
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        fault
);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    localparam logic [32:0] MEM_LIMIT = 33'(MEM_BYTES);

    state_t      state_r;
    logic [31:0] pc_r;
    logic        inflight_r;
    logic [31:0] inflight_pc_r;
    logic [31:0] head_instr_r;
    logic [31:0] head_pc_r;
    logic [31:0] tail_instr_r;
    logic [31:0] tail_pc_r;
    logic [1:0]  count_r;
    logic        fault_r;

    logic        pop_s;
    logic [1:0]  occ_s;
    logic        would_issue_s;
    logic        illegal_s;

    // A fetch address is legal only when word-aligned and the whole word lies inside memory.
    function automatic logic addr_illegal(input logic [31:0] addr);
        return (addr[1:0] != 2'b00) || (({1'b0, addr} + 33'd3) >= MEM_LIMIT);
    endfunction

    assign imem_addr = pc_r;
    assign out_valid = (count_r != 2'd0) && (state_r == ST_RUN);
    assign out_instr = head_instr_r;
    assign out_pc    = head_pc_r;
    assign fault     = fault_r;
    assign pop_s     = out_valid && out_ready;

    // Credit check: issue only when the word it returns is guaranteed a buffer slot.
    always_comb begin
        occ_s         = count_r + {1'b0, inflight_r} - {1'b0, pop_s};
        would_issue_s = 1'b0;
        illegal_s     = addr_illegal(pc_r);
        if ((state_r == ST_RUN) && !redirect_valid) begin
            would_issue_s = (occ_s < 2'd2);
        end else begin
            would_issue_s = 1'b0;
        end
    end

    // Fetch state machine, PC, in-flight tracking and skid buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_RUN;
            pc_r          <= RESET_PC;
            inflight_r    <= 1'b0;
            inflight_pc_r <= 32'd0;
            head_instr_r  <= 32'd0;
            head_pc_r     <= 32'd0;
            tail_instr_r  <= 32'd0;
            tail_pc_r     <= 32'd0;
            count_r       <= 2'd0;
            fault_r       <= 1'b0;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (redirect_valid) begin
                        pc_r       <= redirect_pc;
                        inflight_r <= 1'b0;
                        count_r    <= 2'd0;
                    end else if (would_issue_s && illegal_s) begin
                        fault_r    <= 1'b1;
                        state_r    <= ST_HALT;
                        inflight_r <= 1'b0;
                        count_r    <= 2'd0;
                    end else begin
                        // Shift-style FIFO: the head register always feeds decode directly.
                        case ({pop_s, inflight_r})
                            2'b11: begin
                                if (count_r == 2'd1) begin
                                    head_instr_r <= imem_rdata;
                                    head_pc_r    <= inflight_pc_r;
                                end else begin
                                    head_instr_r <= tail_instr_r;
                                    head_pc_r    <= tail_pc_r;
                                    tail_instr_r <= imem_rdata;
                                    tail_pc_r    <= inflight_pc_r;
                                end
                            end
                            2'b10: begin
                                head_instr_r <= tail_instr_r;
                                head_pc_r    <= tail_pc_r;
                                count_r      <= count_r - 2'd1;
                            end
                            2'b01: begin
                                if (count_r == 2'd0) begin
                                    head_instr_r <= imem_rdata;
                                    head_pc_r    <= inflight_pc_r;
                                end else begin
                                    tail_instr_r <= imem_rdata;
                                    tail_pc_r    <= inflight_pc_r;
                                end
                                count_r <= count_r + 2'd1;
                            end
                            default: begin
                                count_r <= count_r;
                            end
                        endcase
                        if (would_issue_s) begin
                            inflight_r    <= 1'b1;
                            inflight_pc_r <= pc_r;
                            pc_r          <= pc_r + 32'd4;
                        end else begin
                            inflight_r <= 1'b0;
                        end
                    end
                end
                ST_HALT: begin
                    inflight_r <= 1'b0;
                    count_r    <= 2'd0;
                end
                default: begin
                    state_r    <= ST_HALT;
                    fault_r    <= 1'b1;
                    inflight_r <= 1'b0;
                    count_r    <= 2'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: expected fetch PCs are queued by the stimulus
// and a negedge monitor checks every presented output against the queue head.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'd0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        fault;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_q[$];

    fetch_sequencer #(.RESET_PC(32'd0), .MEM_BYTES(2048)) dut (
        .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_pc(out_pc), .fault(fault)
    );

    always #5 clk = ~clk;

    // Memory contents: each word encodes its own address under a fixed tag.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hC0DE_0000 | {16'h0000, a[15:0]};
    endfunction

    always @(posedge clk) imem_rdata <= mem_word(imem_addr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_seq(input logic [31:0] start, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(start + 32'(4 * i));
    endtask

    // Monitor: every presented word must match the queue head; it is popped on transfer.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_out actual_pc=%h expected=none t=%0t", out_pc, $time);
            end else begin
                check("out_pc", out_pc, exp_q[0]);
                check("out_instr", out_instr, mem_word(exp_q[0]));
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int fault_edge;
        // Reset state
        @(negedge clk);
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_pc", out_pc, 32'd0);
        check("rst_instr", out_instr, 32'd0);
        check("rst_addr", imem_addr, 32'd0);
        check("rst_fault", {31'd0, fault}, 32'd0);

        // Straight-line fetch from 0
        push_seq(32'd0, 64);
        step();
        rst_n = 1'b1;
        step();
        @(negedge clk);
        check("first_edge_valid", {31'd0, out_valid}, 32'd0);
        check("first_edge_addr", imem_addr, 32'd4);
        step();
        @(negedge clk);
        check("second_edge_valid", {31'd0, out_valid}, 32'd1);
        check("second_edge_pc", out_pc, 32'd0);
        repeat (6) step();

        // Backpressure for 5 cycles; the monitor peeks the head while stalled
        out_ready = 1'b0;
        repeat (5) step();
        @(negedge clk);
        check("stall_valid", {31'd0, out_valid}, 32'd1);
        step();
        out_ready = 1'b1;
        repeat (4) step();

        // Redirect in steady state (count=1, inflight=1)
        redirect_valid = 1'b1;
        redirect_pc = 32'h40;
        step();
        redirect_valid = 1'b0;
        exp_q.delete();
        push_seq(32'h40, 64);
        @(negedge clk);
        check("redir_gap1_valid", {31'd0, out_valid}, 32'd0);
        check("redir_addr", imem_addr, 32'h40);
        step();
        @(negedge clk);
        check("redir_gap2_valid", {31'd0, out_valid}, 32'd0);
        step();
        @(negedge clk);
        check("redir_target_valid", {31'd0, out_valid}, 32'd1);
        check("redir_target_pc", out_pc, 32'h40);
        repeat (3) step();

        // Redirect while stalled with a full buffer
        out_ready = 1'b0;
        repeat (3) step();
        redirect_valid = 1'b1;
        redirect_pc = 32'h100;
        step();
        redirect_valid = 1'b0;
        exp_q.delete();
        push_seq(32'h100, 64);
        out_ready = 1'b1;
        @(negedge clk);
        check("stall_redir_valid", {31'd0, out_valid}, 32'd0);
        step();
        step();
        @(negedge clk);
        check("stall_redir_pc", out_pc, 32'h100);
        repeat (3) step();

        // Misaligned redirect target traps one edge later
        redirect_valid = 1'b1;
        redirect_pc = 32'h42;
        step();
        redirect_valid = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("mis_fault_pre", {31'd0, fault}, 32'd0);
        check("mis_addr", imem_addr, 32'h42);
        step();
        @(negedge clk);
        check("mis_fault", {31'd0, fault}, 32'd1);
        check("mis_valid", {31'd0, out_valid}, 32'd0);
        step();
        redirect_valid = 1'b1;
        redirect_pc = 32'h0;
        step();
        redirect_valid = 1'b0;
        repeat (3) step();
        check("halt_addr_frozen", imem_addr, 32'h42);
        check("halt_fault", {31'd0, fault}, 32'd1);
        check("halt_valid", {31'd0, out_valid}, 32'd0);

        // Asynchronous reset clears the trap and fetch restarts at RESET_PC
        #2;
        rst_n = 1'b0;
        #1;
        check("areset_fault", {31'd0, fault}, 32'd0);
        check("areset_addr", imem_addr, 32'd0);
        step();
        rst_n = 1'b1;
        push_seq(32'd0, 64);
        step();
        step();
        @(negedge clk);
        check("restart_valid", {31'd0, out_valid}, 32'd1);
        check("restart_pc", out_pc, 32'd0);
        step();

        // Sequential fall-off at the end of memory
        redirect_valid = 1'b1;
        redirect_pc = 32'h7F0;
        step();
        redirect_valid = 1'b0;
        exp_q.delete();
        push_seq(32'h7F0, 3);
        fault_edge = 0;
        for (int i = 1; i <= 10; i++) begin
            step();
            @(negedge clk);
            if (fault) begin
                fault_edge = i;
                break;
            end
        end
        check("eom_fault_edge", 32'(fault_edge), 32'd5);
        check("eom_valid", {31'd0, out_valid}, 32'd0);
        check("eom_addr", imem_addr, 32'd2048);
        check("eom_drained", 32'(exp_q.size()), 32'd0);

        // Reset mid-stream zeroes the outputs without a clock edge
        #2;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        exp_q.delete();
        push_seq(32'd0, 64);
        repeat (6) step();
        @(negedge clk);
        check("mid_valid_before", {31'd0, out_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_pc", out_pc, 32'd0);
        check("mid_rst_instr", out_instr, 32'd0);
        check("mid_rst_addr", imem_addr, 32'd0);
        exp_q.delete();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
